// File: rtl/layer_priority_ctrl.sv
// layer_priority_ctrl: per-pixel layer arbiter in front of the palette lookup.
// Picks the highest-priority opaque layer (frog > car > log > bg), animates the
// three water palette entries, and presents the result with a fixed 2-cycle
// latency. It also accumulates per-frame frog overlap flags for game logic.
//
// Ports
//   Clk            in   pixel clock
//   Reset          in   synchronous, active-high
//   pix_en         in   active-video pixel strobe
//   frame_start    in   1-cycle pulse on the first cycle of each frame
//   frog_idx       in   frog sprite palette index
//   car_idx        in   car layer palette index
//   log_idx        in   log layer palette index
//   bg_idx         in   background palette index (always opaque)
//   color_idx      out  winning palette index
//   color_vld      out  color_idx valid (pix_en delayed 2 cycles)
//   anim_phase     out  current water phase 0..2
//   frog_on_car    out  last frame: frog overlapped a car pixel
//   frog_on_log    out  last frame: frog overlapped a log pixel
//   frog_in_water  out  last frame: frog overlapped bare water background
module layer_priority_ctrl #(
    parameter int unsigned IDX_W       = 8,
    parameter int unsigned TRANSP_IDX  = 0,
    parameter int unsigned WATER_BASE  = 15,
    parameter int unsigned ANIM_FRAMES = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             pix_en,
    input  logic             frame_start,
    input  logic [IDX_W-1:0] frog_idx,
    input  logic [IDX_W-1:0] car_idx,
    input  logic [IDX_W-1:0] log_idx,
    input  logic [IDX_W-1:0] bg_idx,
    output logic [IDX_W-1:0] color_idx,
    output logic             color_vld,
    output logic [1:0]       anim_phase,
    output logic             frog_on_car,
    output logic             frog_on_log,
    output logic             frog_in_water
);

    localparam int unsigned CNT_W = 8;

    localparam logic [IDX_W-1:0] TRANSP   = IDX_W'(TRANSP_IDX);
    localparam logic [IDX_W-1:0] WATER_LO = IDX_W'(WATER_BASE);
    localparam logic [IDX_W-1:0] WATER_HI = IDX_W'(WATER_BASE + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_FRAMES - 1);

    // Stage 1 registers
    logic             pix_en_q;
    logic [IDX_W-1:0] frog_q;
    logic [IDX_W-1:0] car_q;
    logic [IDX_W-1:0] log_q;
    logic [IDX_W-1:0] bg_q;

    // Animation and collision state
    logic [CNT_W-1:0] frame_cnt;
    logic             acc_car;
    logic             acc_log;
    logic             acc_water;

    // Stage 2 combinational decode
    logic             frog_op;
    logic             car_op;
    logic             log_op;
    logic             bg_water;
    logic [1:0]       water_rel;
    logic [2:0]       water_sum;
    logic [1:0]       water_mod;
    logic [IDX_W-1:0] water_idx;
    logic [IDX_W-1:0] win_idx;
    logic             hit_car;
    logic             hit_log;
    logic             hit_water;

    // Layer opacity and water-range detection on the registered indices
    always_comb begin
        frog_op   = (frog_q != TRANSP);
        car_op    = (car_q  != TRANSP);
        log_op    = (log_q  != TRANSP);
        bg_water  = (bg_q >= WATER_LO) && (bg_q <= WATER_HI);
        water_rel = 2'(bg_q - WATER_LO);
        water_sum = 3'(water_rel) + 3'(anim_phase);
        // Sum is at most 4, so one conditional subtract implements mod 3
        water_mod = (water_sum >= 3'd3) ? 2'(water_sum - 3'd3) : 2'(water_sum);
        water_idx = WATER_LO + IDX_W'(water_mod);
    end

    // Priority select: frog > car > log > bg (bg remapped when it is water)
    always_comb begin
        win_idx = bg_q;
        if (frog_op) begin
            win_idx = frog_q;
        end else if (car_op) begin
            win_idx = car_q;
        end else if (log_op) begin
            win_idx = log_q;
        end else if (bg_water) begin
            win_idx = water_idx;
        end
    end

    // Overlap hits are only meaningful for active-video pixels
    always_comb begin
        hit_car   = pix_en_q && frog_op && car_op;
        hit_log   = pix_en_q && frog_op && log_op;
        hit_water = pix_en_q && frog_op && !car_op && !log_op && bg_water;
    end

    // Pixel pipeline
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_en_q  <= 1'b0;
            frog_q    <= '0;
            car_q     <= '0;
            log_q     <= '0;
            bg_q      <= '0;
            color_idx <= '0;
            color_vld <= 1'b0;
        end else begin
            pix_en_q  <= pix_en;
            frog_q    <= frog_idx;
            car_q     <= car_idx;
            log_q     <= log_idx;
            bg_q      <= bg_idx;
            color_idx <= pix_en_q ? win_idx : '0;
            color_vld <= pix_en_q;
        end
    end

    // Water animation: phase advances once every ANIM_FRAMES frames
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt  <= '0;
            anim_phase <= 2'd0;
        end else if (frame_start) begin
            if (frame_cnt == CNT_LAST) begin
                frame_cnt  <= '0;
                anim_phase <= (anim_phase == 2'd2) ? 2'd0 : anim_phase + 2'd1;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    // Sticky collision accumulators; a hit coincident with frame_start
    // seeds the new frame rather than the one being reported
    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc_car       <= 1'b0;
            acc_log       <= 1'b0;
            acc_water     <= 1'b0;
            frog_on_car   <= 1'b0;
            frog_on_log   <= 1'b0;
            frog_in_water <= 1'b0;
        end else if (frame_start) begin
            frog_on_car   <= acc_car;
            frog_on_log   <= acc_log;
            frog_in_water <= acc_water;
            acc_car       <= hit_car;
            acc_log       <= hit_log;
            acc_water     <= hit_water;
        end else begin
            acc_car   <= acc_car   | hit_car;
            acc_log   <= acc_log   | hit_log;
            acc_water <= acc_water | hit_water;
        end
    end

endmodule
